// File: rtl/rv32_writeback_if.sv
// Writeback stage bundle: ALU results, load issue/response, register file port.
// RV32_WB_FWD_EN adds the early-forward outputs.
interface rv32_writeback_if #(
  parameter int XPR_LEN        = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      alu_valid;
  logic                      alu_ready;
  logic [REG_ADDR_WIDTH-1:0] alu_rd;
  logic [XPR_LEN-1:0]        alu_data;
  logic                      ld_issue;
  logic                      ld_ready;
  logic [REG_ADDR_WIDTH-1:0] ld_rd;
  logic [2:0]                ld_funct3;
  logic [1:0]                ld_addr_lo;
  logic                      ld_resp_valid;
  logic [XPR_LEN-1:0]        ld_resp_data;
  logic                      rf_wen;
  logic [REG_ADDR_WIDTH-1:0] rf_wa;
  logic [XPR_LEN-1:0]        rf_wd;
  logic [31:0]               busy_mask;
`ifdef RV32_WB_FWD_EN
  logic                      fwd_valid;
  logic [REG_ADDR_WIDTH-1:0] fwd_rd;
  logic [XPR_LEN-1:0]        fwd_data;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue, ld_rd, ld_funct3, ld_addr_lo,
    input  ld_resp_valid, ld_resp_data,
    output alu_ready, ld_ready,
    output rf_wen, rf_wa, rf_wd, busy_mask,
    output fwd_valid, fwd_rd, fwd_data
  );
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue, ld_rd, ld_funct3, ld_addr_lo,
    output ld_resp_valid, ld_resp_data,
    input  alu_ready, ld_ready,
    input  rf_wen, rf_wa, rf_wd, busy_mask,
    input  fwd_valid, fwd_rd, fwd_data
  );
`else
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue, ld_rd, ld_funct3, ld_addr_lo,
    input  ld_resp_valid, ld_resp_data,
    output alu_ready, ld_ready,
    output rf_wen, rf_wa, rf_wd, busy_mask
  );
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue, ld_rd, ld_funct3, ld_addr_lo,
    output ld_resp_valid, ld_resp_data,
    input  alu_ready, ld_ready,
    input  rf_wen, rf_wa, rf_wd, busy_mask
  );
`endif
endinterface

// File: rtl/rv32_writeback.sv
// Writeback stage: merges ALU results and load responses onto the RF write port.
// Optional macro RV32_WB_FWD_EN: combinational forward of the selected write.
module rv32_writeback #(
  parameter int XPR_LEN        = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  rv32_writeback_if.slave wb
);
  localparam int PW = $clog2(ALU_FIFO_DEPTH);

  typedef logic [REG_ADDR_WIDTH-1:0] ra_t;
  typedef logic [XPR_LEN-1:0]        xd_t;
  typedef enum logic {IDLE, WAIT} st_e;

  st_e                     state_q;
  ra_t                     ld_rd_q;
  logic [2:0]              ld_f3_q;
  logic [1:0]              ld_lo_q;
  ra_t                     fifo_rd_q [ALU_FIFO_DEPTH];
  xd_t                     fifo_wd_q [ALU_FIFO_DEPTH];
  logic [ALU_FIFO_DEPTH-1:0] fifo_v_q;
  logic [PW-1:0]           rp_q;
  logic [PW-1:0]           wp_q;
  logic                    rf_wen_q;
  ra_t                     rf_wa_q;
  xd_t                     rf_wd_q;

  logic        fifo_full;
  logic        fifo_empty;
  logic        acc;
  logic        ld_sel;
  logic        fifo_sel;
  logic        direct;
  logic        push;
  logic        sel_wen;
  ra_t         sel_wa;
  xd_t         sel_wd;
  xd_t         sh;
  xd_t         ld_ext;
  logic [31:0] busy;

  // Ring with per-slot valid: slot at wp is occupied only when full.
  assign fifo_full  = fifo_v_q[wp_q];
  assign fifo_empty = !fifo_v_q[rp_q];
  assign acc        = wb.alu_valid && !fifo_full;
  assign ld_sel     = (state_q == WAIT) && wb.ld_resp_valid;
  assign fifo_sel   = !ld_sel && !fifo_empty;
  assign direct     = !ld_sel && fifo_empty
                      && acc && (wb.alu_rd != '0);
  assign push       = acc && (wb.alu_rd != '0) && !direct;

  always_comb begin
    sh     = '0;
    ld_ext = wb.ld_resp_data;
    unique case (ld_f3_q)
      3'd0, 3'd4: begin
        sh     = wb.ld_resp_data >> {ld_lo_q, 3'b000};
        ld_ext = {{(XPR_LEN-8){sh[7] & ~ld_f3_q[2]}}, sh[7:0]};
      end
      3'd1, 3'd5: begin
        sh     = wb.ld_resp_data >> {ld_lo_q[1], 4'b0000};
        ld_ext = {{(XPR_LEN-16){sh[15] & ~ld_f3_q[2]}}, sh[15:0]};
      end
      default: ld_ext = wb.ld_resp_data;
    endcase
  end

  always_comb begin
    sel_wen = 1'b0;
    sel_wa  = ld_rd_q;
    sel_wd  = ld_ext;
    unique case (1'b1)
      ld_sel: sel_wen = (ld_rd_q != '0);
      fifo_sel: begin
        sel_wen = 1'b1;
        sel_wa  = fifo_rd_q[rp_q];
        sel_wd  = fifo_wd_q[rp_q];
      end
      direct: begin
        sel_wen = 1'b1;
        sel_wa  = wb.alu_rd;
        sel_wd  = wb.alu_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = '0;
    if (state_q == WAIT) busy[ld_rd_q] = 1'b1;
    for (int i = 0; i < ALU_FIFO_DEPTH; i++)
      if (fifo_v_q[i]) busy[fifo_rd_q[i]] = 1'b1;
`ifdef RV32_WB_FWD_EN
    if (sel_wen) busy[sel_wa] = 1'b0;
`endif
    busy[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ld_rd_q  <= '0;
      ld_f3_q  <= '0;
      ld_lo_q  <= '0;
      fifo_v_q <= '0;
      rp_q     <= '0;
      wp_q     <= '0;
      rf_wen_q <= 1'b0;
      rf_wa_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (wb.ld_issue) begin
          state_q <= WAIT;
          ld_rd_q <= wb.ld_rd;
          ld_f3_q <= wb.ld_funct3;
          ld_lo_q <= wb.ld_addr_lo;
        end
        WAIT: if (wb.ld_resp_valid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (push) begin
        fifo_v_q[wp_q] <= 1'b1;
        wp_q           <= wp_q + 1'b1;
      end
      if (fifo_sel) begin
        fifo_v_q[rp_q] <= 1'b0;
        rp_q           <= rp_q + 1'b1;
      end
      rf_wen_q <= sel_wen;
      if (sel_wen) begin
        rf_wa_q <= sel_wa;
        rf_wd_q <= sel_wd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wp_q] <= wb.alu_rd;
      fifo_wd_q[wp_q] <= wb.alu_data;
    end
  end

  assign wb.alu_ready = !fifo_full;
  assign wb.ld_ready  = (state_q == IDLE);
  assign wb.rf_wen    = rf_wen_q;
  assign wb.rf_wa     = rf_wa_q;
  assign wb.rf_wd     = rf_wd_q;
  assign wb.busy_mask = busy;
`ifdef RV32_WB_FWD_EN
  assign wb.fwd_valid = sel_wen;
  assign wb.fwd_rd    = sel_wa;
  assign wb.fwd_data  = sel_wd;
`endif
endmodule

// File: tb/tb_rv32_writeback.sv
// Directed bench for rv32_writeback: ALU/load merge, extraction, busy mask, reset.
module tb_rv32_writeback;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rv32_writeback_if #(.XPR_LEN(32), .REG_ADDR_WIDTH(5)) wb();

  rv32_writeback #(
    .XPR_LEN(32), .REG_ADDR_WIDTH(5), .ALU_FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb(wb)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] d;
    logic [31:0] e;
  } lv_t;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    wb.alu_valid     = 1'b0;
    wb.alu_rd        = '0;
    wb.alu_data      = '0;
    wb.ld_issue      = 1'b0;
    wb.ld_rd         = '0;
    wb.ld_funct3     = '0;
    wb.ld_addr_lo    = '0;
    wb.ld_resp_valid = 1'b0;
    wb.ld_resp_data  = '0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    wb.alu_valid = 1'b1;
    wb.alu_rd    = rd;
    wb.alu_data  = d;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3,
                       input logic [1:0] lo);
    wb.ld_issue   = 1'b1;
    wb.ld_rd      = rd;
    wb.ld_funct3  = f3;
    wb.ld_addr_lo = lo;
  endtask

  task automatic wr(string tag, logic [4:0] wa, logic [31:0] wd);
    chk({tag, ".wen"}, 32'(wb.rf_wen), 32'd1);
    chk({tag, ".wa"}, 32'(wb.rf_wa), 32'(wa));
    chk({tag, ".wd"}, wb.rf_wd, wd);
  endtask

  lv_t vec[6];

  initial begin
    vec[0] = '{3'd1, 2'd2, 32'h8001_0000, 32'hFFFF_8001};
    vec[1] = '{3'd4, 2'd1, 32'h0000_AB00, 32'h0000_00AB};
    vec[2] = '{3'd2, 2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vec[3] = '{3'd3, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vec[4] = '{3'd0, 2'd0, 32'h1234_567F, 32'h0000_007F};
    vec[5] = '{3'd1, 2'd3, 32'h1234_5678, 32'h0000_1234};

    quiet();
    rst = 1'b1;
    step();
    step();
    chk("rst.wen", 32'(wb.rf_wen), 32'd0);
    chk("rst.wa", 32'(wb.rf_wa), 32'd0);
    chk("rst.wd", wb.rf_wd, 32'd0);
    chk("rst.busy", wb.busy_mask, 32'd0);
    chk("rst.ldrdy", 32'(wb.ld_ready), 32'd1);
    chk("rst.alurdy", 32'(wb.alu_ready), 32'd1);
    rst = 1'b0;
    step();

    // Direct ALU write, never busy.
    alu(5'd5, 32'h1234);
    step();
    quiet();
    wr("alu1", 5'd5, 32'h1234);
    chk("alu1.busy", wb.busy_mask, 32'd0);
    step();
    chk("alu1.pulse", 32'(wb.rf_wen), 32'd0);

    // lb rd7 lo3, response two cycles after issue.
    issue(5'd7, 3'd0, 2'd3);
    step();
    quiet();
    chk("lb.busy1", wb.busy_mask, 32'h80);
    chk("lb.ldrdy1", 32'(wb.ld_ready), 32'd0);
    step();
    chk("lb.busy2", wb.busy_mask, 32'h80);
    chk("lb.ldrdy2", 32'(wb.ld_ready), 32'd0);
    wb.ld_resp_valid = 1'b1;
    wb.ld_resp_data  = 32'h80FF_FF00;
    step();
    quiet();
    wr("lb", 5'd7, 32'hFFFF_FF80);
    chk("lb.ldrdy3", 32'(wb.ld_ready), 32'd1);
    step();
    chk("lb.busy3", wb.busy_mask, 32'd0);
    chk("lb.pulse", 32'(wb.rf_wen), 32'd0);

    // lhu response colliding with ALU rd3.
    issue(5'd9, 3'd5, 2'd2);
    step();
    quiet();
    wb.ld_resp_valid = 1'b1;
    wb.ld_resp_data  = 32'hBEEF_0001;
    alu(5'd3, 32'h11);
    step();
    quiet();
    wr("lhu", 5'd9, 32'h0000_BEEF);
    chk("lhu.busy", wb.busy_mask, 32'h8);
    step();
    wr("col.alu", 5'd3, 32'h11);
    chk("col.busy", wb.busy_mask, 32'd0);
    step();
    chk("col.pulse", 32'(wb.rf_wen), 32'd0);

    // Fill the FIFO behind alternating load responses.
    issue(5'd10, 3'd2, 2'd0);
    step();
    quiet();
    wb.ld_resp_valid = 1'b1;
    wb.ld_resp_data  = 32'hA0A0_A0A0;
    alu(5'd1, 32'h101);
    step();
    quiet();
    wr("f.ld10", 5'd10, 32'hA0A0_A0A0);
    issue(5'd11, 3'd2, 2'd0);
    alu(5'd2, 32'h102);
    step();
    quiet();
    wr("f.x1", 5'd1, 32'h101);
    wb.ld_resp_valid = 1'b1;
    wb.ld_resp_data  = 32'hB0B0_B0B0;
    alu(5'd3, 32'h103);
    step();
    quiet();
    wr("f.ld11", 5'd11, 32'hB0B0_B0B0);
    chk("f.full", 32'(wb.alu_ready), 32'd0);
    chk("f.busy", wb.busy_mask, 32'hC);
    alu(5'd4, 32'h104);
    step();
    wr("f.x2", 5'd2, 32'h102);
    chk("f.rdy", 32'(wb.alu_ready), 32'd1);
    step();
    quiet();
    wr("f.x3", 5'd3, 32'h103);
    step();
    wr("f.x4", 5'd4, 32'h104);
    step();
    chk("f.pulse", 32'(wb.rf_wen), 32'd0);

    // x0 targets.
    alu(5'd0, 32'hFFFF_FFFF);
    step();
    quiet();
    chk("x0.alu", 32'(wb.rf_wen), 32'd0);
    chk("x0.alurdy", 32'(wb.alu_ready), 32'd1);
    issue(5'd0, 3'd2, 2'd0);
    step();
    quiet();
    chk("x0.ldrdy", 32'(wb.ld_ready), 32'd0);
    chk("x0.busy", wb.busy_mask, 32'd0);
    wb.ld_resp_valid = 1'b1;
    wb.ld_resp_data  = 32'h5555_5555;
    step();
    quiet();
    chk("x0.ld", 32'(wb.rf_wen), 32'd0);
    chk("x0.idle", 32'(wb.ld_ready), 32'd1);
    chk("x0.busy2", wb.busy_mask, 32'd0);

    // Extraction table.
    for (int i = 0; i < 6; i++) begin
      issue(5'd20, vec[i].f3, vec[i].lo);
      step();
      quiet();
      wb.ld_resp_valid = 1'b1;
      wb.ld_resp_data  = vec[i].d;
      step();
      quiet();
      wr($sformatf("ext%0d", i), 5'd20, vec[i].e);
    end
    step();

    // Reset while a write, a load and a FIFO entry are in flight.
    issue(5'd12, 3'd2, 2'd0);
    step();
    quiet();
    wb.ld_resp_valid = 1'b1;
    alu(5'd13, 32'h113);
    step();
    quiet();
    issue(5'd12, 3'd2, 2'd0);
    alu(5'd14, 32'h114);
    step();
    quiet();
    wb.ld_resp_valid = 1'b1;
    alu(5'd15, 32'h115);
    step();
    quiet();
    chk("r.busyfull", wb.busy_mask, 32'h0000_C000);
    chk("r.full", 32'(wb.alu_ready), 32'd0);
    issue(5'd16, 3'd2, 2'd0);
    step();
    quiet();
    wr("r.x14", 5'd14, 32'h114);
    chk("r.busy", wb.busy_mask, 32'h0001_8000);
    #2;
    rst = 1'b1;
    #1;
    chk("r.wen", 32'(wb.rf_wen), 32'd0);
    chk("r.busy0", wb.busy_mask, 32'd0);
    chk("r.ldrdy", 32'(wb.ld_ready), 32'd1);
    chk("r.alurdy", 32'(wb.alu_ready), 32'd1);
    step();
    rst = 1'b0;
    wb.ld_resp_valid = 1'b1;
    wb.ld_resp_data  = 32'h7777_7777;
    step();
    quiet();
    chk("r.stray", 32'(wb.rf_wen), 32'd0);
    step();
    chk("r.none", 32'(wb.rf_wen), 32'd0);
    chk("r.busy1", wb.busy_mask, 32'd0);
    chk("r.ldrdy1", 32'(wb.ld_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
